// File: rtl/cplx_neg_rot_if.sv
// Handshake and data bundle for the cplx_neg_rot trivial-twiddle rotator.
// The slave modport is the rotator side and the master modport is the driver side.
`timescale 1ns/1ps
interface cplx_neg_rot_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic [1:0]              in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic                    out_ovf;
    logic                    ovf_clr;
    logic [CNT_W-1:0]        ovf_count;

    modport slave (
        input  in_valid, in_re, in_im, in_mode, out_ready, ovf_clr,
        output in_ready, out_valid, out_re, out_im, out_ovf, ovf_count
    );

    modport master (
        output in_valid, in_re, in_im, in_mode, out_ready, ovf_clr,
        input  in_ready, out_valid, out_re, out_im, out_ovf, ovf_count
    );
endinterface

// File: rtl/cplx_neg_rot.sv
// Two-stage complex rotator by 1, -1, -j or +j with most-negative overflow flagging.
// Defining CPLX_NEG_SAT_EN makes an overflowing negation saturate instead of wrap.
`timescale 1ns/1ps
module cplx_neg_rot #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    cplx_neg_rot_if.slave bus
);
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

`ifdef CPLX_NEG_SAT_EN
    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic signed [WIDTH-1:0] sat_neg(
        input logic signed [WIDTH-1:0] neg,
        input logic                    ovf
    );
        return ovf ? MAX_VAL : neg;
    endfunction
`endif

    logic                    w_adv1;
    logic                    w_adv2;
    logic                    w_in_xfer;
    logic                    w_out_xfer;

    logic                    r_vld_p1;
    logic signed [WIDTH-1:0] r_re_p1;
    logic signed [WIDTH-1:0] r_im_p1;
    logic signed [WIDTH-1:0] r_inv_re_p1;
    logic signed [WIDTH-1:0] r_inv_im_p1;
    logic [1:0]              r_mode_p1;

    logic signed [WIDTH-1:0] w_neg_re;
    logic signed [WIDTH-1:0] w_neg_im;
    logic                    w_ovf_re;
    logic                    w_ovf_im;
    logic signed [WIDTH-1:0] w_re_p2;
    logic signed [WIDTH-1:0] w_im_p2;
    logic                    w_ovf_p2;

    logic                    r_vld_p2;
    logic signed [WIDTH-1:0] r_re_p2;
    logic signed [WIDTH-1:0] r_im_p2;
    logic                    r_ovf_p2;
    logic [CNT_W-1:0]        r_ovf_count;

    // in_ready depends only on registered valids and out_ready, never on in_valid
    assign w_adv2     = !r_vld_p2 || bus.out_ready;
    assign w_adv1     = !r_vld_p1 || w_adv2;
    assign w_in_xfer  = bus.in_valid && w_adv1;
    assign w_out_xfer = r_vld_p2 && bus.out_ready;

    // ---- stage 1: capture raw and inverted operands plus mode ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1    <= 1'b0;
            r_re_p1     <= '0;
            r_im_p1     <= '0;
            r_inv_re_p1 <= '0;
            r_inv_im_p1 <= '0;
            r_mode_p1   <= 2'b00;
        end else if (w_adv1) begin
            r_vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_re_p1     <= bus.in_re;
                r_im_p1     <= bus.in_im;
                r_inv_re_p1 <= ~bus.in_re;
                r_inv_im_p1 <= ~bus.in_im;
                r_mode_p1   <= bus.in_mode;
            end
        end
    end

    // ---- stage 2: complete the negation and select by mode ----
    assign w_neg_re = r_inv_re_p1 + ONE;
    assign w_neg_im = r_inv_im_p1 + ONE;
    assign w_ovf_re = (r_re_p1 == MIN_VAL);
    assign w_ovf_im = (r_im_p1 == MIN_VAL);

    always_comb begin
        logic signed [WIDTH-1:0] v_nre;
        logic signed [WIDTH-1:0] v_nim;
`ifdef CPLX_NEG_SAT_EN
        v_nre = sat_neg(w_neg_re, w_ovf_re);
        v_nim = sat_neg(w_neg_im, w_ovf_im);
`else
        v_nre = w_neg_re;
        v_nim = w_neg_im;
`endif
        w_re_p2  = r_re_p1;
        w_im_p2  = r_im_p1;
        w_ovf_p2 = 1'b0;
        case (r_mode_p1)
            2'b01: begin
                w_re_p2  = v_nre;
                w_im_p2  = v_nim;
                w_ovf_p2 = w_ovf_re || w_ovf_im;
            end
            2'b10: begin
                w_re_p2  = r_im_p1;
                w_im_p2  = v_nre;
                w_ovf_p2 = w_ovf_re;
            end
            2'b11: begin
                w_re_p2  = v_nim;
                w_im_p2  = r_re_p1;
                w_ovf_p2 = w_ovf_im;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p2 <= 1'b0;
            r_re_p2  <= '0;
            r_im_p2  <= '0;
            r_ovf_p2 <= 1'b0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_re_p2  <= w_re_p2;
                r_im_p2  <= w_im_p2;
                r_ovf_p2 <= w_ovf_p2;
            end
        end
    end

    // ---- overflow event counter on output transfers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_count <= '0;
        end else if (bus.ovf_clr) begin
            r_ovf_count <= (w_out_xfer && r_ovf_p2) ? CNT_W'(1) : '0;
        end else if (w_out_xfer && r_ovf_p2 && (r_ovf_count != CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_vld_p2;
    assign bus.out_re    = r_re_p2;
    assign bus.out_im    = r_im_p2;
    assign bus.out_ovf   = r_ovf_p2;
    assign bus.ovf_count = r_ovf_count;
endmodule

// File: tb/tb_cplx_neg_rot.sv
// Directed bench for cplx_neg_rot: reset, mode arithmetic, overflow, backpressure, counter.
`timescale 1ns/1ps
module tb_cplx_neg_rot;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

`ifdef CPLX_NEG_SAT_EN
    localparam logic [31:0] NEG_MIN = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] NEG_MIN = 32'h8000_0000;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    cplx_neg_rot_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    cplx_neg_rot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] re, input logic [31:0] im,
                         input logic [1:0] mode);
        bus.in_valid = v;
        bus.in_re    = re;
        bus.in_im    = im;
        bus.in_mode  = mode;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] re, input logic [31:0] im,
                           input logic ovf);
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_re"}, bus.out_re, re);
        chk({tag, "_im"}, bus.out_im, im);
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
    endtask

    initial begin
        int exp_re[4];
        int exp_im[4];
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_re", bus.out_re, 32'd0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // single sample, mode -1
        drive(1'b1, 32'd5, -32'sd3, 2'b01);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        chk("lat1_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk_out("neg5", 32'hFFFF_FFFB, 32'd3, 1'b0);
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        // back-to-back stream of all four modes
        exp_re = '{7, -7, 2, -2};
        exp_im = '{2, -2, -7, 7};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 32'd7, 32'd2, 2'(i));
            else       drive(1'b0, 32'd0, 32'd0, 2'b00);
            tick();
            if (i >= 1) chk_out($sformatf("stream%0d", i - 1), exp_re[i-1], exp_im[i-1], 1'b0);
        end
        tick();

        // most-negative operand
        drive(1'b1, 32'h8000_0000, 32'd1, 2'b01);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        tick();
        chk_out("ovf_m01", NEG_MIN, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk("ovf_count1", 32'(bus.ovf_count), 32'd1);
        drive(1'b1, 32'h8000_0000, 32'd1, 2'b00);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        tick();
        chk_out("min_m00", 32'h8000_0000, 32'd1, 1'b0);
        tick();
        chk("ovf_count_hold", 32'(bus.ovf_count), 32'd1);
        drive(1'b1, 32'd4, 32'h8000_0000, 2'b11);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        tick();
        chk_out("ovf_m11", NEG_MIN, 32'd4, 1'b1);
        tick();
        chk("ovf_count2", 32'(bus.ovf_count), 32'd2);

        // backpressure: three samples against a stalled output
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd20, 2'b00);
        chk("bp_rdy_a", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 32'd11, 32'd21, 2'b00);
        chk("bp_rdy_b", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 32'd12, 32'd22, 2'b00);
        chk("bp_rdy_c", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        chk("bp_rdy_c2", 32'(bus.in_ready), 32'd0);
        chk_out("bp_hold", 32'd10, 32'd20, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 32'(bus.in_ready), 32'd1);
        chk_out("bp_a", 32'd10, 32'd20, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        chk_out("bp_b", 32'd11, 32'd21, 1'b0);
        tick();
        chk_out("bp_c", 32'd12, 32'd22, 1'b0);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // reset with two samples in flight
        drive(1'b1, 32'h8000_0000, 32'd0, 2'b01);
        tick();
        drive(1'b1, 32'd3, 32'd3, 2'b00);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        chk("rf_pre_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rf_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rf_ovf_count", 32'(bus.ovf_count), 32'd0);
        chk("rf_out_re", bus.out_re, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rf_stale%0d", i), 32'(bus.out_valid), 32'd0);
        end

        // counter saturation and clear
        drive(1'b1, 32'h8000_0000, 32'd5, 2'b01);
        for (int i = 0; i < 260; i++) tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_count", 32'(bus.ovf_count), 32'd255);
        drive(1'b1, 32'h8000_0000, 32'd5, 2'b01);
        tick();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        tick();
        chk("clr_pre_ovf", 32'(bus.out_ovf), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("clr_inc_count", 32'(bus.ovf_count), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("clr_only_count", 32'(bus.ovf_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
